// File: rtl/yarvi_uart_tx.sv
// yarvi_uart_tx -- serial transmit end of the console byte stream.
// Bytes are accepted on a valid/ready stream and always written into a small
// FIFO. The FIFO head is serialised as an asynchronous frame:
// a start bit, 8 data bits LSB first, an optional even-parity bit, and
// STOP_BITS stop bits. Each bit lasts DIVISOR clocks.
// Back-to-back frames are sent with no idle gap between them.
// Build option: define YARVI_UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit(s).
`timescale 1ns/1ps
module yarvi_uart_tx #(
  parameter int DIVISOR   = 868,  // clocks per bit period, 2..65535
  parameter int FIFO_LOG2 = 4,    // log2 of FIFO depth, 1..8
  parameter int STOP_BITS = 1     // 1 or 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       serial_out,
  output logic       busy
);

  localparam int                   DEPTH       = 1 << FIFO_LOG2;
  localparam int                   CNT_W       = FIFO_LOG2 + 1;
  localparam logic [15:0]          BAUD_RELOAD = 16'(DIVISOR - 1);
  localparam logic [15:0]          STOP_RELOAD = 16'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]     FULL_COUNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE     = FIFO_LOG2'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef YARVI_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [7:0]           fifo_mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [7:0]           fifo_head;

  // Ready only depends on the registered count, so a pop on the same edge
  // as a full condition frees the slot one cycle later.
  assign tx_ready   = (count_q != FULL_COUNT);
  assign push       = tx_valid & tx_ready;
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = fifo_mem[rd_ptr_q];

  // Storage write port: every accepted byte lands here, there is no bypass.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= tx_data;
    end
  end

  // Pointer and occupancy next-state; simultaneous push and pop keep count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO bookkeeping registers; reset discards any queued bytes.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Frame serialiser
  // ---------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] stop_cnt_q, stop_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        serial_q, serial_d;
  logic        busy_q, busy_d;
`ifdef YARVI_UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  // Transmit FSM next-state: every bit is held for DIVISOR clocks by counting
  // baud down to zero and reloading it at the bit transition.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    stop_cnt_d = stop_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    serial_d   = serial_q;
    pop        = 1'b0;
`ifdef YARVI_UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = fifo_head;
          serial_d = 1'b0;
          baud_d   = BAUD_RELOAD;
          state_d  = S_START;
`ifdef YARVI_UART_TX_PARITY_EN
          parity_d = ^fifo_head;
`endif
        end
      end

      S_START: begin
        if (baud_q == '0) begin
          serial_d  = shift_q[0];
          bit_idx_d = '0;
          baud_d    = BAUD_RELOAD;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end

      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_idx_q == 3'd7) begin
`ifdef YARVI_UART_TX_PARITY_EN
            serial_d = parity_q;
            state_d  = S_PARITY;
`else
            serial_d   = 1'b1;
            stop_cnt_d = STOP_RELOAD;
            state_d    = S_STOP;
`endif
          end else begin
            // Next data bit is the one just above the current LSB.
            shift_d   = {1'b0, shift_q[7:1]};
            serial_d  = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end

`ifdef YARVI_UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_q == '0) begin
          serial_d   = 1'b1;
          stop_cnt_d = STOP_RELOAD;
          baud_d     = BAUD_RELOAD;
          state_d    = S_STOP;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif

      S_STOP: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (stop_cnt_q != '0) begin
            // Another full stop-bit period follows.
            stop_cnt_d = stop_cnt_q - 16'd1;
          end else if (!fifo_empty) begin
            // Chain straight into the next frame with no idle gap.
            pop      = 1'b1;
            shift_d  = fifo_head;
            serial_d = 1'b0;
            state_d  = S_START;
`ifdef YARVI_UART_TX_PARITY_EN
            parity_d = ^fifo_head;
`endif
          end else begin
            baud_d  = '0;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end

      default: begin
        serial_d = 1'b1;
        baud_d   = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // busy tracks the post-edge state so it falls on the same edge the line idles.
  assign busy_d = (state_d != S_IDLE) | (count_d != '0);

  // FSM and output registers; reset abandons any frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      stop_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      serial_q   <= 1'b1;
      busy_q     <= 1'b0;
`ifdef YARVI_UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      stop_cnt_q <= stop_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      serial_q   <= serial_d;
      busy_q     <= busy_d;
`ifdef YARVI_UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign serial_out = serial_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_yarvi_uart_tx.sv
// tb_yarvi_uart_tx -- directed self-checking bench for yarvi_uart_tx.
// Runs with DIVISOR=4, FIFO_LOG2=4, STOP_BITS=1; the parity scenario is
// included when YARVI_UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_yarvi_uart_tx;

  localparam int DIV   = 4;
  localparam int STOPB = 1;
  localparam int FLOG2 = 4;
`ifdef YARVI_UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = 9 + PAR_BITS + STOPB;
  localparam int FRAME_CYC  = FRAME_BITS * DIV;

  logic       clock;
  logic       reset;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       serial_out;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       frame_ok;
  } rx_t;

  rx_t rx_q[$];

  yarvi_uart_tx #(
    .DIVISOR  (DIV),
    .FIFO_LOG2(FLOG2),
    .STOP_BITS(STOPB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .serial_out(serial_out),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected line level for bit slot b of a frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PAR_BITS == 1 && b == 9) return ^d;
    return 1'b1;
  endfunction

  // Line-level receiver: detects a start edge, samples mid-bit, queues bytes.
  initial begin : line_monitor
    int         cnt;
    int         b;
    bit         active;
    logic [7:0] d;
    logic       p;
    logic       ok;
    rx_t        r;
    cnt = 0; b = 0; active = 0; d = '0; p = 1'b0; ok = 1'b0; r = '0;
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        active = 0;
      end else if (!active) begin
        if (serial_out === 1'b0) begin
          active = 1; cnt = 0; d = '0; p = 1'b0; ok = 1'b1;
        end
      end else begin
        cnt++;
        if (cnt % DIV == DIV / 2) begin
          b = cnt / DIV;
          if (b == 0) begin
            if (serial_out !== 1'b0) ok = 1'b0;
          end else if (b <= 8) begin
            d[b-1] = serial_out;
          end else if (PAR_BITS == 1 && b == 9) begin
            p = serial_out;
          end else begin
            if (serial_out !== 1'b1) ok = 1'b0;
            if (b == FRAME_BITS - 1) begin
              r.data = d; r.par = p; r.frame_ok = ok;
              rx_q.push_back(r);
              active = 0;
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    int bad;
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    checks++;
    if (serial_out !== 1'b1) begin failures++; $display("FAIL reset_serial: got %b expected 1", serial_out); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
    tick();
    checks++;
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b expected 1", tx_ready); end
    bad = 0;
    repeat (100) begin
      tick();
      if (serial_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL idle_line: bad cycles %0d expected 0", bad); end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    logic [127:0] got;
    logic [127:0] exp;
    got = '0; exp = '0;
    rx_q.delete();
    tx_data = 8'h55; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0; tx_data = 8'hAA;  // must not affect the queued byte
    checks++;
    if (serial_out !== 1'b1) begin failures++; $display("FAIL single_latency: got %b expected 1 at push edge", serial_out); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_rise: got %b expected 1", busy); end
    for (int k = 0; k < FRAME_CYC; k++) begin
      tick();
      got[k] = serial_out;
      exp[k] = frame_bit(8'h55, k / DIV);
    end
    checks++;
    if (got !== exp) begin failures++; $display("FAIL single_frame: got %h expected %h", got, exp); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_last: got %b expected 1", busy); end
    tick();
    checks++;
    if (busy !== 1'b0 || serial_out !== 1'b1) begin
      failures++; $display("FAIL single_busy_fall: busy=%b serial=%b expected 0/1", busy, serial_out);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0].data !== 8'h55 || rx_q[0].frame_ok !== 1'b1) begin
      failures++; $display("FAIL single_rx: got %0d frames first=%h expected 1 frame 55", rx_q.size(), (rx_q.size() > 0) ? rx_q[0].data : 8'h00);
    end
    $display("test_single: byte 55 sent");
  endtask

  task automatic test_back_to_back();
    logic [127:0] got;
    logic [127:0] exp;
    got = '0; exp = '0;
    rx_q.delete();
    tx_valid = 1'b1; tx_data = 8'h00;
    tick();
    tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    got[0] = serial_out;
    for (int k = 1; k < 2 * FRAME_CYC; k++) begin
      tick();
      got[k] = serial_out;
    end
    for (int k = 0; k < 2 * FRAME_CYC; k++) begin
      exp[k] = (k < FRAME_CYC) ? frame_bit(8'h00, k / DIV) : frame_bit(8'hFF, (k - FRAME_CYC) / DIV);
    end
    checks++;
    if (got !== exp) begin failures++; $display("FAIL b2b_frames: got %h expected %h", got, exp); end
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_fall: got %b expected 0", busy); end
    checks++;
    if (rx_q.size() != 2 || rx_q[0].data !== 8'h00 || rx_q[1].data !== 8'hFF) begin
      failures++; $display("FAIL b2b_rx: got %0d frames expected 2 (00,FF)", rx_q.size());
    end
    $display("test_back_to_back: bytes 00 FF sent");
  endtask

  task automatic test_fifo_full();
    int   nxt;
    int   n;
    logic acc;
    rx_q.delete();
    nxt = 0;
    for (int i = 0; i < 30; i++) begin
      tx_data = 8'(nxt); tx_valid = 1'b1;
      checks++;
      if (tx_ready !== ((i <= 16) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL full_ready cycle %0d: got %b expected %b", i, tx_ready, (i <= 16));
      end
      acc = tx_ready;
      tick();
      if (acc) nxt++;
    end
    tx_valid = 1'b0;
    checks++;
    if (nxt != 17) begin failures++; $display("FAIL full_accepted: got %0d expected 17", nxt); end
    for (int e = 30; e <= FRAME_CYC; e++) begin
      tick();
      checks++;
      if (tx_ready !== 1'b0) begin failures++; $display("FAIL full_hold edge %0d: got %b expected 0", e, tx_ready); end
    end
    tick();
    checks++;
    if (tx_ready !== 1'b1 || serial_out !== 1'b0) begin
      failures++; $display("FAIL full_reready: ready=%b serial=%b expected 1/0", tx_ready, serial_out);
    end
    n = 0;
    while (busy !== 1'b0 && n < 17 * FRAME_CYC + 100) begin tick(); n++; end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL full_drain: busy=%b expected 0 within bound", busy); end
    checks++;
    if (rx_q.size() != 17) begin failures++; $display("FAIL full_count: got %0d frames expected 17", rx_q.size()); end
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (rx_q.size() <= i || rx_q[i].data !== 8'(i) || rx_q[i].frame_ok !== 1'b1) begin
        failures++; $display("FAIL full_order %0d: got %h expected %h", i, (rx_q.size() > i) ? rx_q[i].data : 8'hxx, 8'(i));
      end
    end
    $display("test_fifo_full: %0d bytes accepted", nxt);
  endtask

  task automatic test_reset_mid();
    int bad;
    int n;
    rx_q.delete();
    tx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_data = (i == 0) ? 8'hA5 : 8'(8'h10 + i);
      tick();
    end
    tx_valid = 1'b0;
    repeat (12) tick();
    checks++;
    if (serial_out !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL mid_bit3: serial=%b busy=%b expected 0/1", serial_out, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (serial_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      failures++; $display("FAIL mid_reset: serial=%b busy=%b ready=%b expected 1/0/1", serial_out, busy, tx_ready);
    end
    bad = 0;
    repeat (200) begin
      tick();
      if (serial_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || rx_q.size() != 0) begin
      failures++; $display("FAIL mid_quiet: bad cycles %0d frames %0d expected 0/0", bad, rx_q.size());
    end
    tx_valid = 1'b1; tx_data = 8'h3C;
    tick();
    tx_valid = 1'b0;
    n = 0;
    while ((busy !== 1'b0 || rx_q.size() == 0) && n < FRAME_CYC + 20) begin tick(); n++; end
    checks++;
    if (rx_q.size() != 1 || rx_q[0].data !== 8'h3C) begin
      failures++; $display("FAIL mid_restart: got %0d frames first=%h expected 1 frame 3C", rx_q.size(), (rx_q.size() > 0) ? rx_q[0].data : 8'h00);
    end
    $display("test_reset_mid: reset during A5 bit 3");
  endtask

`ifdef YARVI_UART_TX_PARITY_EN
  task automatic test_parity();
    logic [127:0] got;
    logic [127:0] exp;
    got = '0; exp = '0;
    rx_q.delete();
    tx_valid = 1'b1; tx_data = 8'h07;
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < FRAME_CYC; k++) begin
      tick();
      got[k] = serial_out;
      exp[k] = frame_bit(8'h07, k / DIV);
    end
    checks++;
    if (got !== exp) begin failures++; $display("FAIL parity_frame: got %h expected %h", got, exp); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL parity_len_last: busy=%b expected 1", busy); end
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL parity_len_end: busy=%b expected 0", busy); end
    checks++;
    if (rx_q.size() != 1 || rx_q[0].par !== 1'b1) begin
      failures++; $display("FAIL parity_07: frames=%0d par=%b expected 1", rx_q.size(), (rx_q.size() > 0) ? rx_q[0].par : 1'bx);
    end
    rx_q.delete();
    tx_valid = 1'b1; tx_data = 8'h03;
    tick();
    tx_valid = 1'b0;
    repeat (FRAME_CYC + 2) tick();
    checks++;
    if (rx_q.size() != 1 || rx_q[0].par !== 1'b0 || rx_q[0].data !== 8'h03) begin
      failures++; $display("FAIL parity_03: frames=%0d par=%b expected 0", rx_q.size(), (rx_q.size() > 0) ? rx_q[0].par : 1'bx);
    end
    $display("test_parity: bytes 07 03 sent");
  endtask
`endif

  initial begin
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    test_reset();
    test_single();
    repeat (5) tick();
    test_back_to_back();
    repeat (5) tick();
    test_fifo_full();
    repeat (5) tick();
    test_reset_mid();
`ifdef YARVI_UART_TX_PARITY_EN
    repeat (5) tick();
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/yarvi_uart_tx.md
Name: yarvi_uart_tx

Overview:
- Serial transmit end of the SoC's byte-stream console interface.
- Accepts bytes on a valid/ready stream (tx_valid/tx_ready/tx_data, same semantics as the SoC's tx port) and buffers them in a small FIFO.
- Serialises each byte as an 8N1 asynchronous frame on a single line.
- Sits between yarvi_soc's tx stream and the board/bench serial pin; the bench pairs it with a line-level receiver.

Parameters:
- DIVISOR, 868, clocks per bit period (100 MHz / 115200); legal range 2..65535.
- FIFO_LOG2, 4, log2 of FIFO depth (depth 16); legal range 1..8.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_valid  input  1  producer has a byte on tx_data.
- tx_ready  output  1  FIFO can accept; transfer occurs on an edge where tx_valid and tx_ready are both 1.
- tx_data  input  8  byte to send.
- serial_out  output  1  UART line; idle high; registered output.
- busy  output  1  frame in progress or FIFO non-empty; registered.

Behaviour:
- Reset (edge with reset=1):
  - serial_out=1, busy=0.
  - FIFO count=0, read/write pointers=0, FSM=IDLE, baud counter=0, bit index=0.
  - tx_ready is 1 from the first cycle after reset deasserts.
- FIFO:
  - tx_ready = (count != 2**FIFO_LOG2), combinational from registered count.
  - Push on tx_valid & tx_ready; pop when the FSM leaves IDLE.
  - Push and pop on the same edge leave count unchanged; pointers wrap modulo depth.
  - Full: tx_ready=0, tx_data ignored. A pop on the same edge does not raise tx_ready until the next cycle.
  - No bypass path: every byte is written to the FIFO first.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when FIFO non-empty. Pop the head into an 8-bit shift register, serial_out<=0, baud counter<=DIVISOR-1.
  - Each state holds its bit for exactly DIVISOR cycles; the baud counter decrements to 0, then reloads DIVISOR-1 at the transition.
  - START -> DATA: serial_out<=shift[0], bit index<=0.
  - DATA: send LSB first; at each bit end, shift right and increment the index. After bit 7 -> STOP with serial_out<=1.
  - STOP lasts STOP_BITS*DIVISOR cycles. Then:
    - FIFO non-empty: go directly to START (pop, serial_out<=0). No idle gap between back-to-back frames.
    - FIFO empty: go to IDLE.
- Timing:
  - A byte accepted at edge N with FSM in IDLE: serial_out falls after edge N+1.
  - Frame length = (9+STOP_BITS)*DIVISOR cycles.
- busy = (FSM != IDLE) | (count != 0), registered, updated every edge.
- tx_data is sampled only at the push edge; later changes to tx_data have no effect.
- Reset mid-frame: at the reset edge serial_out returns to 1, the frame is abandoned (no completion) and FIFO contents are discarded.
- Widths: the baud counter and stop counter are 16 bits; the count register is FIFO_LOG2+1 bits.

Optional Feature:
- Macro: YARVI_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting DIVISOR cycles.
  - serial_out = even parity (XOR of the 8 data bits).
  - Frame length = (10+STOP_BITS)*DIVISOR.
- Undefined: no PARITY state; 8N1/8N2 framing as above.

Test Plan:
- Bench DIVISOR=4, STOP_BITS=1, parity off unless stated.
- Reset held 3 cycles, then released -> serial_out=1, busy=0, tx_ready=1 on the first post-reset cycle; line stays 1 for 100 idle cycles.
- Push 0x55 once -> serial_out falls one cycle after the push. Sequence in 4-cycle bits: 0 (start), 1,0,1,0,1,0,1,0, then 1 (stop). busy drops 41 cycles after the push.
- Push 0x00 then 0xFF on consecutive cycles -> two 40-cycle frames with no idle gap: start, eight 0s, stop 1, start 0, eight 1s, stop 1.
- Hold tx_valid=1 for 30 cycles with an incrementing byte (FIFO_LOG2=4):
  - tx_ready falls once 16 bytes are buffered beyond the one being sent.
  - Accepted bytes appear on the line in order, none lost or duplicated.
  - tx_ready re-rises the cycle after each pop.
- Assert reset during the DATA bit 3 of 0xA5, with 5 bytes queued -> serial_out=1 after the reset edge, busy=0, and no further frames until new pushes.
- With YARVI_UART_TX_PARITY_EN, push 0x07 (three 1s) -> parity bit 1, frame 44 cycles. Push 0x03 -> parity bit 0.
